rotating_shift_register: RTL and testbench



---
 rtl/mux2to1.sv | 19 +
 rtl/shift_bit_cell.sv | 71 +++++++
 rtl/rotating_shift_register.sv | 72 +++++++
 tb/tb_rotating_shift_register.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mux2to1.sv
// Purpose: single-bit 2-to-1 multiplexer; y = a when sel=0, b when sel=1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, the output follows the inputs.
//
// Ports:
//   sel - select (0 -> a, 1 -> b)
//   a   - input chosen when sel=0
//   b   - input chosen when sel=1
//   y   - selected output
module mux2to1 (
    input  logic sel,
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/shift_bit_cell.sv
// Purpose: one bit of the rotating shift register: direction, hold and load muxes feeding a flop.
// Latency: one clock from control/data sample to q_out.
// Backpressure: none; the bit updates on every rising edge per its controls.
//
// Ports:
//   clock           - rising-edge clock
//   reset           - synchronous, active-high; clears the bit
//   left_in         - value this bit takes on a left rotate (its lower neighbour)
//   right_in        - value this bit takes on a right shift/rotate (its upper neighbour)
//   load_val        - parallel load value for this bit
//   rotate_right    - 1 selects right_in, 0 selects left_in
//   parallel_load_n - active-low load; overrides enable
//   enable          - 1 applies the shift, 0 holds
//   q_out           - registered bit value
module shift_bit_cell (
    input  logic clock,
    input  logic reset,
    input  logic left_in,
    input  logic right_in,
    input  logic load_val,
    input  logic rotate_right,
    input  logic parallel_load_n,
    input  logic enable,
    output logic q_out
);

    logic dir_sel;
    logic hold_sel;
    logic load_sel;
    logic q_d;
    logic q_q;

    mux2to1 u_dir_mux (
        .sel (rotate_right),
        .a   (left_in),
        .b   (right_in),
        .y   (dir_sel)
    );

    // enable=0 recirculates the current value.
    mux2to1 u_hold_mux (
        .sel (enable),
        .a   (q_q),
        .b   (dir_sel),
        .y   (hold_sel)
    );

    // Load sits after the hold mux so a load happens regardless of enable.
    mux2to1 u_load_mux (
        .sel (parallel_load_n),
        .a   (load_val),
        .b   (hold_sel),
        .y   (load_sel)
    );

    always_comb begin
        q_d = load_sel;
    end

    // Reset is checked ahead of q_d so unknown controls cannot reach the flop while reset is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_out = q_q;

endmodule

// File: rtl/rotating_shift_register.sv
// Purpose: WIDTH-bit register with parallel load, rotate left/right and arithmetic shift right.
// Latency: one clock from control/data sample to q; q has no combinational input path.
// Backpressure: none; enable=0 holds, parallel_load_n=0 loads regardless of enable.
//
// Ports:
//   clock           - rising-edge clock
//   reset           - synchronous, active-high; clears q
//   enable          - 1 performs the selected shift, 0 holds (does not gate loads)
//   parallel_load_n - active-low parallel load of data_in
//   rotate_right    - 1 shifts toward bit 0, 0 rotates toward the MSB
//   asr             - with rotate_right=1, replicate the sign bit instead of wrapping q[0]
//   data_in         - parallel load value
//   q               - registered contents
module rotating_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             parallel_load_n,
    input  logic             rotate_right,
    input  logic             asr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_bits;
    logic             msb_right_src;

    // The MSB's right-shift source is the only place rotate and ASR differ:
    // q[0] closes the ring, q[WIDTH-1] replicates the sign.
    mux2to1 u_msb_src_mux (
        .sel (asr),
        .a   (q_bits[0]),
        .b   (q_bits[WIDTH-1]),
        .y   (msb_right_src)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic left_src;
        logic right_src;

        // Left rotate: bit i takes bit i-1, with bit 0 taking the MSB.
        if (i == 0) begin : g_left_wrap
            assign left_src = q_bits[WIDTH-1];
        end else begin : g_left_inner
            assign left_src = q_bits[i-1];
        end

        // Right shift: bit i takes bit i+1, with the MSB taking the asr-selected source.
        if (i == WIDTH-1) begin : g_right_msb
            assign right_src = msb_right_src;
        end else begin : g_right_inner
            assign right_src = q_bits[i+1];
        end

        shift_bit_cell u_cell (
            .clock           (clock),
            .reset           (reset),
            .left_in         (left_src),
            .right_in        (right_src),
            .load_val        (data_in[i]),
            .rotate_right    (rotate_right),
            .parallel_load_n (parallel_load_n),
            .enable          (enable),
            .q_out           (q_bits[i])
        );
    end

    assign q = q_bits;

endmodule

// File: tb/tb_rotating_shift_register.sv
module tb_rotating_shift_register;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         parallel_load_n;
    logic         rotate_right;
    logic         asr;
    logic [W-1:0] data_in;
    logic [W-1:0] q;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] model_q     = '0;

    always #5 clock = ~clock;

    rotating_shift_register #(.WIDTH(W)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .parallel_load_n (parallel_load_n),
        .rotate_right    (rotate_right),
        .asr             (asr),
        .data_in         (data_in),
        .q               (q)
    );

    task automatic check_q(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: q=%h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the priority rules, using plain arithmetic.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic rst,
                                              input logic pl_n, input logic en, input logic rr,
                                              input logic a, input logic [W-1:0] din);
        logic [W-1:0] r;
        if (rst)           r = '0;
        else if (!pl_n)    r = din;
        else if (!en)      r = cur;
        else if (rr && !a) r = (cur >> 1) | (cur << (W-1));
        else if (rr)       r = $signed(cur) >>> 1;
        else               r = (cur << 1) | (cur >> (W-1));
        return r;
    endfunction

    // Drive controls, take one rising edge, then compare against the model.
    task automatic cyc(input logic rst, input logic pl_n, input logic en, input logic rr,
                       input logic a, input logic [W-1:0] din, input string tag);
        reset           = rst;
        parallel_load_n = pl_n;
        enable          = en;
        rotate_right    = rr;
        asr             = a;
        data_in         = din;
        @(posedge clock);
        model_q = ref_next(model_q, rst, pl_n, en, rr, a, din);
        #1;
        check_q(tag, q, model_q);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; parallel_load_n = 1'b1;
        rotate_right = 1'b0; asr = 1'b0; data_in = '0;
        #2;

        // Reset wins over a simultaneous load.
        cyc(1, 0, 1, 0, 0, 8'hFF, "reset_wins");
        check_q("reset_val", q, 8'h00);

        // Load then rotate right, with wrap-around after W rotates.
        cyc(0, 0, 1, 0, 0, 8'h81, "load_81");
        check_q("load_81_val", q, 8'h81);
        cyc(0, 1, 1, 1, 0, 8'h00, "ror_1");
        check_q("ror_1_val", q, 8'hC0);
        for (int i = 0; i < W-1; i++) cyc(0, 1, 1, 1, 0, 8'h00, "ror_n");
        check_q("ror_wrap", q, 8'h81);

        // Rotate left ignores asr.
        cyc(0, 0, 0, 0, 0, 8'h81, "load_81b");
        cyc(0, 1, 1, 0, 1, 8'h00, "rol_asr");
        check_q("rol_val", q, 8'h03);
        for (int i = 0; i < W-1; i++) cyc(0, 1, 1, 0, 0, 8'h00, "rol_n");
        check_q("rol_wrap", q, 8'h81);

        // ASR and saturation.
        cyc(0, 0, 1, 1, 1, 8'h90, "load_90");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1, 8'h00, "asr_n");
        check_q("asr_3", q, 8'hF2);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 1, 8'h00, "asr_n");
        check_q("asr_sat", q, 8'hFF);
        for (int i = 0; i < 2; i++) cyc(0, 1, 1, 1, 1, 8'h00, "asr_n");
        check_q("asr_hold", q, 8'hFF);
        cyc(0, 0, 1, 1, 1, 8'h70, "load_70");
        for (int i = 0; i < W; i++) cyc(0, 1, 1, 1, 1, 8'h00, "asr_pos");
        check_q("asr_sat0", q, 8'h00);

        // Hold with rotate_right toggling, then load with enable low.
        cyc(0, 0, 1, 0, 0, 8'hA5, "load_a5");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, i[0], 0, 8'h00, "hold");
        check_q("hold_val", q, 8'hA5);
        cyc(0, 0, 0, 1, 0, 8'h3C, "load_no_en");
        check_q("load_no_en_val", q, 8'h3C);

        // Reset mid-rotation, no residual state afterwards.
        cyc(0, 0, 1, 0, 0, 8'h81, "load_81c");
        cyc(0, 1, 1, 1, 0, 8'h00, "ror_pre");
        cyc(1, 1, 1, 1, 0, 8'h00, "mid_reset");
        check_q("mid_reset_val", q, 8'h00);
        cyc(0, 1, 1, 1, 0, 8'h00, "post_reset");
        check_q("post_reset_val", q, 8'h00);

        // Unknown controls during reset must not reach q.
        cyc(0, 0, 1, 0, 0, 8'h5A, "load_5a");
        cyc(1, 1'bx, 1'bx, 1'bx, 1'bx, 8'hxx, "x_reset");
        check_q("x_reset_val", q, 8'h00);

        // Randomized traffic; also confirm q is stable between edges.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                W'($urandom), "random");
            if (n % 4 == 0) begin
                reset = 1'($urandom); parallel_load_n = 1'($urandom);
                enable = 1'($urandom); rotate_right = 1'($urandom);
                asr = 1'($urandom); data_in = W'($urandom);
                #2;
                check_q("no_comb_path", q, model_q);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
